// File: rtl/bp_update_queue.sv
// Branch-resolution sink: registered fetch redirect on mispredict plus a small FIFO
// of predictor update records with redundant-update filtering and drop counting.

package bp_pkg;
    typedef enum logic [1:0] {
        CF_BRANCH = 2'd0,
        CF_JUMP   = 2'd1,
        CF_CALL   = 2'd2,
        CF_RET    = 2'd3
    } controlflow_t;

    typedef struct packed {
        logic         valid;
        logic         mispredict;
        logic [31:0]  pc;
        logic [31:0]  target;
        logic         taken;
        logic [1:0]   counter;
        controlflow_t cf;
    } branch_resolved_t;
endpackage

module bp_update_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  bp_pkg::branch_resolved_t resolved_branch,
    output logic                     redirect_valid,
    output logic [31:0]              redirect_pc,
    output logic                     update_valid,
    input  logic                     update_ready,
    output logic [31:0]              update_pc,
    output logic [31:0]              update_target,
    output logic                     update_taken,
    output logic [1:0]               update_counter,
    output bp_pkg::controlflow_t     update_cf,
    output logic [7:0]               drop_count
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [31:0]          pc;
        logic [31:0]          target;
        logic                 taken;
        logic [1:0]           counter;
        bp_pkg::controlflow_t cf;
    } record_t;

    record_t     mem [DEPTH];
    logic [AW:0] wr_ptr_reg, wr_ptr_next;
    logic [AW:0] rd_ptr_reg, rd_ptr_next;
    logic [7:0]  drop_count_reg, drop_count_next;
    logic        redirect_valid_reg, redirect_valid_next;
    logic [31:0] redirect_pc_reg, redirect_pc_next;

    logic        fifo_empty, fifo_full;
    logic        event_valid, saturated, push_req, pop, push_accept;
    logic [1:0]  new_counter;
    record_t     push_rec;

    assign event_valid = resolved_branch.valid;

    always_comb begin
        new_counter = resolved_branch.counter;
        if (resolved_branch.taken) begin
            if (resolved_branch.counter != 2'd3)
                new_counter = resolved_branch.counter + 2'd1;
        end else begin
            if (resolved_branch.counter != 2'd0)
                new_counter = resolved_branch.counter - 2'd1;
        end
    end

    // A correctly predicted branch whose counter is already pinned in that direction adds nothing.
    assign saturated = resolved_branch.taken ? (resolved_branch.counter == 2'd3)
                                             : (resolved_branch.counter == 2'd0);
    assign push_req  = event_valid &&
                       !(!resolved_branch.mispredict && saturated && (new_counter == resolved_branch.counter));

    assign fifo_empty  = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full   = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                         (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign pop         = !fifo_empty && update_ready;
    assign push_accept = push_req && (!fifo_full || pop);

    assign push_rec.pc      = resolved_branch.pc;
    assign push_rec.target  = resolved_branch.target;
    assign push_rec.taken   = resolved_branch.taken;
    assign push_rec.counter = new_counter;
    assign push_rec.cf      = resolved_branch.cf;

    always_comb begin
        wr_ptr_next         = wr_ptr_reg;
        rd_ptr_next         = rd_ptr_reg;
        drop_count_next     = drop_count_reg;
        redirect_valid_next = 1'b0;
        redirect_pc_next    = redirect_pc_reg;
        if (push_accept)
            wr_ptr_next = wr_ptr_reg + 1'b1;
        if (pop)
            rd_ptr_next = rd_ptr_reg + 1'b1;
        if (push_req && !push_accept && drop_count_reg != 8'hFF)
            drop_count_next = drop_count_reg + 8'd1;
        // Not-taken redirect skips the delay slot.
        if (event_valid && resolved_branch.mispredict) begin
            redirect_valid_next = 1'b1;
            redirect_pc_next    = resolved_branch.taken ? resolved_branch.target
                                                        : resolved_branch.pc + 32'd8;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg         <= '0;
            rd_ptr_reg         <= '0;
            drop_count_reg     <= '0;
            redirect_valid_reg <= 1'b0;
            redirect_pc_reg    <= '0;
        end else begin
            wr_ptr_reg         <= wr_ptr_next;
            rd_ptr_reg         <= rd_ptr_next;
            drop_count_reg     <= drop_count_next;
            redirect_valid_reg <= redirect_valid_next;
            redirect_pc_reg    <= redirect_pc_next;
        end
    end

    // Storage has no reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push_accept)
            mem[wr_ptr_reg[AW-1:0]] <= push_rec;
    end

    record_t head_rec;
    assign head_rec = mem[rd_ptr_reg[AW-1:0]];

    assign redirect_valid = redirect_valid_reg;
    assign redirect_pc    = redirect_pc_reg;
    assign update_valid   = !fifo_empty;
    assign update_pc      = head_rec.pc;
    assign update_target  = head_rec.target;
    assign update_taken   = head_rec.taken;
    assign update_counter = head_rec.counter;
    assign update_cf      = head_rec.cf;
    assign drop_count     = drop_count_reg;
endmodule

// File: tb/tb_bp_update_queue.sv
// Directed bench for bp_update_queue: redirect, counter/filter, full/drop, reset mid-drain.

module tb_bp_update_queue;
    import bp_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n;
    branch_resolved_t rb;
    logic             redirect_valid;
    logic [31:0]      redirect_pc;
    logic             update_valid;
    logic             update_ready;
    logic [31:0]      update_pc;
    logic [31:0]      update_target;
    logic             update_taken;
    logic [1:0]       update_counter;
    controlflow_t     update_cf;
    logic [7:0]       drop_count;

    int checks = 0;
    int passed = 0;
    int failed = 0;

    always #5 clk = ~clk;

    bp_update_queue #(.DEPTH(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .resolved_branch(rb),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .update_valid   (update_valid),
        .update_ready   (update_ready),
        .update_pc      (update_pc),
        .update_target  (update_target),
        .update_taken   (update_taken),
        .update_counter (update_counter),
        .update_cf      (update_cf),
        .drop_count     (drop_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_event(input logic [31:0] pc, input logic [31:0] target, input logic taken,
                             input logic mis, input logic [1:0] cnt, input controlflow_t cf);
        rb.valid      = 1'b1;
        rb.mispredict = mis;
        rb.pc         = pc;
        rb.target     = target;
        rb.taken      = taken;
        rb.counter    = cnt;
        rb.cf         = cf;
    endtask

    task automatic send(input logic [31:0] pc, input logic [31:0] target, input logic taken,
                        input logic mis, input logic [1:0] cnt, input controlflow_t cf);
        set_event(pc, target, taken, mis, cnt, cf);
        step();
        rb = '0;
        $display("event pc=%h target=%h taken=%0d mis=%0d cnt=%0d", pc, target, taken, mis, cnt);
    endtask

    initial begin
        rst_n        = 1'b0;
        rb           = '0;
        update_ready = 1'b0;
        step();
        step();
        check("rst_redirect_valid", 32'(redirect_valid), 32'd0);
        check("rst_redirect_pc", redirect_pc, 32'd0);
        check("rst_update_valid", 32'(update_valid), 32'd0);
        check("rst_drop_count", 32'(drop_count), 32'd0);
        rst_n = 1'b1;
        step();

        // Taken mispredict
        send(32'hBFC00100, 32'hBFC00200, 1'b1, 1'b1, 2'd1, CF_CALL);
        check("tm_redirect_valid", 32'(redirect_valid), 32'd1);
        check("tm_redirect_pc", redirect_pc, 32'hBFC00200);
        check("tm_update_valid", 32'(update_valid), 32'd1);
        check("tm_update_counter", 32'(update_counter), 32'd2);
        check("tm_update_pc", update_pc, 32'hBFC00100);
        check("tm_update_target", update_target, 32'hBFC00200);
        check("tm_update_taken", 32'(update_taken), 32'd1);
        check("tm_update_cf", 32'(update_cf), 32'(CF_CALL));
        update_ready = 1'b1;
        step();
        update_ready = 1'b0;
        check("tm_pop_empty", 32'(update_valid), 32'd0);
        check("tm_redirect_pulse", 32'(redirect_valid), 32'd0);
        check("tm_redirect_hold", redirect_pc, 32'hBFC00200);

        // Not-taken mispredict with PC wrap
        send(32'hFFFFFFFC, 32'h12345678, 1'b0, 1'b1, 2'd0, CF_BRANCH);
        check("nt_redirect_valid", 32'(redirect_valid), 32'd1);
        check("nt_redirect_pc", redirect_pc, 32'h00000004);
        check("nt_update_valid", 32'(update_valid), 32'd1);
        check("nt_update_counter", 32'(update_counter), 32'd0);
        check("nt_update_taken", 32'(update_taken), 32'd0);
        update_ready = 1'b1;
        step();
        update_ready = 1'b0;
        check("nt_pop_empty", 32'(update_valid), 32'd0);

        // Filter
        send(32'h00000100, 32'h00000200, 1'b1, 1'b0, 2'd3, CF_BRANCH);
        check("flt_t3_update_valid", 32'(update_valid), 32'd0);
        check("flt_t3_redirect_valid", 32'(redirect_valid), 32'd0);
        send(32'h00000100, 32'h00000200, 1'b0, 1'b0, 2'd0, CF_BRANCH);
        check("flt_n0_update_valid", 32'(update_valid), 32'd0);
        send(32'h00000104, 32'h00000300, 1'b1, 1'b0, 2'd2, CF_JUMP);
        check("flt_t2_update_valid", 32'(update_valid), 32'd1);
        check("flt_t2_update_counter", 32'(update_counter), 32'd3);
        check("flt_t2_redirect_valid", 32'(redirect_valid), 32'd0);
        update_ready = 1'b1;
        step();
        update_ready = 1'b0;
        send(32'h00000108, 32'h00000400, 1'b0, 1'b0, 2'd2, CF_BRANCH);
        check("flt_n2_update_counter", 32'(update_counter), 32'd1);
        update_ready = 1'b1;
        step();
        update_ready = 1'b0;
        check("flt_drained", 32'(update_valid), 32'd0);

        // Full and drop: 6 events, no pops
        for (int i = 0; i < 6; i++)
            send(32'h1000 + 32'(4 * i), 32'h5000, 1'b1, 1'b0, 2'd1, CF_BRANCH);
        check("full_drop_count", 32'(drop_count), 32'd2);
        check("full_update_valid", 32'(update_valid), 32'd1);
        update_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_valid", 32'(update_valid), 32'd1);
            check("drain_pc", update_pc, 32'h1000 + 32'(4 * i));
            check("drain_counter", 32'(update_counter), 32'd2);
            step();
            $display("pop %0d", i);
        end
        update_ready = 1'b0;
        check("drain_empty", 32'(update_valid), 32'd0);
        check("drain_drop_count", 32'(drop_count), 32'd2);

        // Full with simultaneous pop
        for (int i = 0; i < 4; i++)
            send(32'h2000 + 32'(4 * i), 32'h6000, 1'b1, 1'b0, 2'd0, CF_RET);
        check("fp_drop_before", 32'(drop_count), 32'd2);
        update_ready = 1'b1;
        send(32'h2010, 32'h6000, 1'b1, 1'b0, 2'd0, CF_RET);
        update_ready = 1'b0;
        check("fp_drop_unchanged", 32'(drop_count), 32'd2);
        check("fp_head_pc", update_pc, 32'h2004);
        send(32'h2014, 32'h6000, 1'b1, 1'b0, 2'd0, CF_RET);
        check("fp_still_full", 32'(drop_count), 32'd3);
        update_ready = 1'b1;
        step();
        check("fp_drain_head", update_pc, 32'h2008);

        // Reset mid-drain, with a mispredict pending in the same cycle
        rst_n = 1'b0;
        set_event(32'h3000, 32'h7000, 1'b1, 1'b1, 2'd1, CF_JUMP);
        step();
        rb = '0;
        update_ready = 1'b0;
        check("mrst_update_valid", 32'(update_valid), 32'd0);
        check("mrst_drop_count", 32'(drop_count), 32'd0);
        check("mrst_redirect_valid", 32'(redirect_valid), 32'd0);
        check("mrst_redirect_pc", redirect_pc, 32'd0);
        rst_n = 1'b1;
        step();
        check("post_rst_empty", 32'(update_valid), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
